// File: rtl/d_hazard_scoreboard_pkg.sv
// rtl/d_hazard_scoreboard_pkg.sv - shared pipeline control encodings and hazard timing constants
package d_hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        JC_NONE   = 2'b00,
        JC_BRANCH = 2'b01,
        JC_RSVD   = 2'b10,
        JC_JALR   = 2'b11
    } jump_code_e;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LB   = 3'd1,
        MEM_LH   = 3'd2,
        MEM_LW   = 3'd3,
        MEM_LBU  = 3'd4,
        MEM_LHU  = 3'd5
    } mem_load_e;

    // Age at which an ALU result can be forwarded into E.
    localparam int READY_ALU = 2;

    localparam int                FWD_W  = 3;
    localparam logic [FWD_W-1:0]  FWD_RF = '0;

    function automatic int ready_ld(input int load_lat);
        return READY_ALU + load_lat;
    endfunction

    function automatic int retire_age(input int load_lat);
        return ready_ld(load_lat) + 1;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - busy/age/is_load tracker for one architectural register
module sb_entry
    import d_hazard_scoreboard_pkg::*;
#(
    parameter int AW     = 3,
    parameter int RETIRE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_set,
    input  logic          i_set_load,
    input  logic          i_flush,
    output logic          o_busy,
    output logic [AW-1:0] o_age,
    output logic          o_is_load
);

    localparam logic [AW-1:0] L_RETIRE = AW'(RETIRE);
    localparam logic [AW-1:0] L_ONE    = AW'(1);

    logic          r_busy;
    logic          r_is_load;
    logic [AW-1:0] r_age;
    logic [AW-1:0] w_age_inc;
    logic          w_kill;
    logic          w_retire;

    assign w_age_inc = r_age + L_ONE;
    // A producer still at age 1 sits in E, so a flush of E kills it.
    assign w_kill    = i_flush && (r_age == L_ONE);
    assign w_retire  = (w_age_inc == L_RETIRE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_age     <= '0;
            r_is_load <= 1'b0;
        end else if (i_set) begin
            r_busy    <= 1'b1;
            r_age     <= L_ONE;
            r_is_load <= i_set_load;
        end else if (r_busy) begin
            if (w_kill || w_retire) begin
                r_busy    <= 1'b0;
                r_age     <= '0;
                r_is_load <= 1'b0;
            end else begin
                r_age <= w_age_inc;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_age     = r_age;
    assign o_is_load = r_is_load;

endmodule

// File: rtl/d_hazard_scoreboard.sv
// rtl/d_hazard_scoreboard.sv - decode-stage data hazard scoreboard with stall, predict-block and forward selects
module d_hazard_scoreboard
    import d_hazard_scoreboard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] rs1D,
    input  logic [$clog2(NREGS)-1:0] rs2D,
    input  logic [$clog2(NREGS)-1:0] rdD,
    input  logic                     reg_writeD,
    input  logic [2:0]               mem_loadD,
    input  logic [1:0]               jump_code,
    input  logic                     flushE,
    output logic                     stall,
    output logic                     cannot_predict,
    output logic [FWD_W-1:0]         fwd_sel1E,
    output logic [FWD_W-1:0]         fwd_sel2E
);

    localparam int RW     = $clog2(NREGS);
    localparam int RETIRE = retire_age(LOAD_LAT);
    localparam int AW     = $clog2(RETIRE + 1);

    localparam logic [AW:0] L_RDY_ALU = (AW+1)'(READY_ALU);
    localparam logic [AW:0] L_RDY_LD  = (AW+1)'(ready_ld(LOAD_LAT));
    localparam logic [AW:0] L_FWD_MAX = (AW+1)'(RETIRE - 1);
    localparam logic [AW:0] L_ONE     = (AW+1)'(1);

    typedef struct packed {
        logic             haz;
        logic             nopred;
        logic [FWD_W-1:0] fwd;
    } src_info_t;

    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_is_load;
    logic [NREGS-1:0] w_set;
    logic [AW-1:0]    w_age [NREGS];

    logic             w_accept;
    logic             w_load_d;
    src_info_t        w_src1;
    src_info_t        w_src2;
    logic [FWD_W-1:0] r_fwd_sel1E;
    logic [FWD_W-1:0] r_fwd_sel2E;

    // Entry 0 is never tracked so x0 can never look pending.
    assign w_busy[0]    = 1'b0;
    assign w_is_load[0] = 1'b0;
    assign w_set[0]     = 1'b0;
    assign w_age[0]     = '0;

    assign w_load_d = (mem_loadD != MEM_NONE);

    for (genvar r = 1; r < NREGS; r++) begin : g_entry
        assign w_set[r] = w_accept && reg_writeD && (rdD == RW'(r));

        sb_entry #(
            .AW     (AW),
            .RETIRE (RETIRE)
        ) u_sb_entry (
            .clk        (clk),
            .rst        (rst),
            .i_set      (w_set[r]),
            .i_set_load (w_load_d),
            .i_flush    (flushE),
            .o_busy     (w_busy[r]),
            .o_age      (w_age[r]),
            .o_is_load  (w_is_load[r])
        );
    end

    function automatic src_info_t src_eval(
        input logic          busy,
        input logic [AW-1:0] age,
        input logic          is_load
    );
        src_info_t   res;
        logic [AW:0] a;
        logic [AW:0] a1;
        logic [AW:0] rdy;
        a          = {1'b0, age};
        a1         = a + L_ONE;
        rdy        = is_load ? L_RDY_LD : L_RDY_ALU;
        res.haz    = busy && (a1 < rdy);
        res.nopred = busy && (a < rdy);
        res.fwd    = (busy && (a1 <= L_FWD_MAX)) ? FWD_W'(a1) : FWD_RF;
        return res;
    endfunction

    // Lookups use the pre-edge entries, so an instruction that overwrites its own
    // source still sees the older producer.
    always_comb begin
        w_src1 = src_eval(w_busy[rs1D] && (rs1D != '0), w_age[rs1D], w_is_load[rs1D]);
        w_src2 = src_eval(w_busy[rs2D] && (rs2D != '0), w_age[rs2D], w_is_load[rs2D]);
    end

    assign stall    = !rst && (w_src1.haz || w_src2.haz);
    assign w_accept = issue_valid && !stall;

    always_comb begin
        cannot_predict = 1'b0;
        if (!rst) begin
            case (jump_code)
                JC_BRANCH: cannot_predict = w_src1.nopred || w_src2.nopred;
                JC_JALR:   cannot_predict = w_src1.nopred;
                default:   cannot_predict = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_sel1E <= FWD_RF;
            r_fwd_sel2E <= FWD_RF;
        end else if (w_accept) begin
            r_fwd_sel1E <= w_src1.fwd;
            r_fwd_sel2E <= w_src2.fwd;
        end else begin
            r_fwd_sel1E <= FWD_RF;
            r_fwd_sel2E <= FWD_RF;
        end
    end

    assign fwd_sel1E = r_fwd_sel1E;
    assign fwd_sel2E = r_fwd_sel2E;

endmodule
